// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and filters A/B/index, tracks phase and issues inc/dec/load pulses.
// Optional immediate assertions are compiled in with QUAD_DECODER_ASSERT_EN.
module quad_decoder #(
  parameter int N    = 8,
  parameter int FILT = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         a_in,
  input  logic         b_in,
  input  logic         idx_in,
  input  logic [N-1:0] preset,
  input  logic         err_clr,
  output logic         inc,
  output logic         dec,
  output logic         load,
  output logic [N-1:0] din,
  output logic         err
);

  typedef enum logic [2:0] {
    INIT = 3'd0,
    P00  = 3'd1,
    P01  = 3'd2,
    P11  = 3'd3,
    P10  = 3'd4
  } state_t;

  localparam logic [3:0] FILT_M1 = 4'(FILT - 1);

  state_t     state_r;
  logic [2:0] raw_s;
  logic [2:0] sync1_r;
  logic [2:0] sync2_r;
  logic [1:0] warm_r;
  logic [2:0] filt_s;
  logic [2:0] valid_s;
  logic       idx_prev_r;
  logic [1:0] ab_s;
  logic [1:0] pos_cur_s;
  logic [1:0] pos_new_s;
  logic [1:0] step_s;
  logic       ab_valid_s;
  logic       fwd_s;
  logic       rev_s;
  logic       illegal_s;
  logic       idx_rise_s;

  function automatic state_t phase_of(input logic [1:0] ab);
    case (ab)
      2'b00:   phase_of = P00;
      2'b01:   phase_of = P01;
      2'b11:   phase_of = P11;
      2'b10:   phase_of = P10;
      default: phase_of = P00;
    endcase
  endfunction

  // Position around the forward cycle P00 -> P01 -> P11 -> P10.
  function automatic logic [1:0] pos_of(input state_t s);
    case (s)
      P00:     pos_of = 2'd0;
      P01:     pos_of = 2'd1;
      P11:     pos_of = 2'd2;
      P10:     pos_of = 2'd3;
      default: pos_of = 2'd0;
    endcase
  endfunction

  assign raw_s = {idx_in, b_in, a_in};

  // Two-flop synchronizers; warm_r marks when sync2_r holds real input samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      warm_r  <= 2'b00;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      warm_r  <= {warm_r[0], 1'b1};
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_filt
    logic [3:0] cnt_r;
    logic       filt_r;
    logic       valid_r;

    // Glitch filter; before the first acceptance it tracks the input until stable for FILT cycles.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt_r   <= 4'd0;
        filt_r  <= 1'b0;
        valid_r <= 1'b0;
      end else if (!warm_r[1]) begin
        cnt_r <= 4'd0;
      end else if (!valid_r) begin
        if (sync2_r[g] != filt_r) begin
          filt_r <= sync2_r[g];
          cnt_r  <= 4'd0;
        end else if (cnt_r == FILT_M1) begin
          valid_r <= 1'b1;
          cnt_r   <= 4'd0;
        end else begin
          cnt_r <= cnt_r + 4'd1;
        end
      end else if (sync2_r[g] != filt_r) begin
        if (cnt_r == FILT_M1) begin
          filt_r <= sync2_r[g];
          cnt_r  <= 4'd0;
        end else begin
          cnt_r <= cnt_r + 4'd1;
        end
      end else begin
        cnt_r <= 4'd0;
      end
    end

    assign filt_s[g]  = filt_r;
    assign valid_s[g] = valid_r;
  end

  // Step classification from the accepted phase against the current phase state.
  always_comb begin
    ab_s       = {filt_s[0], filt_s[1]};
    ab_valid_s = valid_s[0] & valid_s[1];
    pos_cur_s  = pos_of(state_r);
    pos_new_s  = pos_of(phase_of(ab_s));
    step_s     = pos_new_s - pos_cur_s;
    idx_rise_s = valid_s[2] & filt_s[2] & ~idx_prev_r;
    if (state_r == INIT) begin
      fwd_s     = 1'b0;
      rev_s     = 1'b0;
      illegal_s = 1'b0;
    end else begin
      fwd_s     = (step_s == 2'd1);
      rev_s     = (step_s == 2'd3);
      illegal_s = (step_s == 2'd2);
    end
  end

  // Phase FSM with registered pulse, load, din and sticky err outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r    <= INIT;
      idx_prev_r <= 1'b0;
      inc        <= 1'b0;
      dec        <= 1'b0;
      load       <= 1'b0;
      din        <= '0;
      err        <= 1'b0;
    end else begin
      idx_prev_r <= filt_s[2];
      load       <= idx_rise_s;
      inc        <= fwd_s & ~idx_rise_s;
      dec        <= rev_s & ~idx_rise_s;
      if (idx_rise_s) begin
        din <= preset;
      end
      if (illegal_s) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
      case (state_r)
        INIT: begin
          if (ab_valid_s) begin
            state_r <= phase_of(ab_s);
          end
        end
        default: state_r <= phase_of(ab_s);
      endcase
    end
  end

`ifdef QUAD_DECODER_ASSERT_EN
  logic illegal_q_r;

  // Run-time consistency checks.
  always_ff @(posedge clk) begin
    illegal_q_r <= reset_n & illegal_s;
    assert (!(inc && dec)) else $error("quad_decoder: inc and dec high together");
    if (reset_n) begin
      assert (!$isunknown({a_in, b_in, idx_in, err_clr}))
        else $info("quad_decoder: unknown value on an input");
    end
    if (illegal_q_r) begin
      assert (err) else $info("quad_decoder: illegal transition did not set err");
    end
  end
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Randomized scoreboard bench for quad_decoder: a phase-table model predicts each pulse and its cycle.
module tb_quad_decoder;
  localparam int N    = 8;
  localparam int FILT = 3;
  localparam int LAT  = FILT + 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         a_in = 1'b0;
  logic         b_in = 1'b0;
  logic         idx_in = 1'b0;
  logic         err_clr = 1'b0;
  logic [N-1:0] preset = '0;
  logic         inc;
  logic         dec;
  logic         load;
  logic [N-1:0] din;
  logic         err;

  quad_decoder #(.N(N), .FILT(FILT)) dut (
    .clk(clk), .reset_n(reset_n), .a_in(a_in), .b_in(b_in), .idx_in(idx_in),
    .preset(preset), .err_clr(err_clr), .inc(inc), .dec(dec), .load(load),
    .din(din), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = inc, 1 = dec, 2 = load
  typedef struct {
    int           kind;
    int           at;
    logic [N-1:0] data;
  } ev_t;

  ev_t  q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: the next forward phase for each {a,b}.
  logic [1:0] nxt [4] = '{2'b01, 2'b11, 2'b00, 2'b10};
  logic [1:0] ab_m  = 2'b00;
  logic       idx_m = 1'b0;
  logic       err_m = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int at, input logic [N-1:0] data);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.data = data;
    q.push_back(e);
  endtask

  // Apply a new settled input level and predict the response.
  task automatic drive(input logic [1:0] nab, input logic nidx);
    logic rise;
    rise = nidx && !idx_m;
    if (rise) begin
      push_ev(2, cyc + LAT, preset);
    end else if (nab != ab_m) begin
      if (nab == nxt[ab_m]) push_ev(0, cyc + LAT, '0);
      else if (ab_m == nxt[nab]) push_ev(1, cyc + LAT, '0);
    end
    if (nab == ~ab_m) err_m = 1'b1;
    ab_m   = nab;
    idx_m  = nidx;
    a_in   = nab[1];
    b_in   = nab[0];
    idx_in = nidx;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    settle(1);
    err_clr = 1'b0;
    err_m   = 1'b0;
    settle(1);
  endtask

  // Monitor: every pulse must match the head of the expected queue in kind, cycle and data.
  always @(negedge clk) begin : mon
    ev_t e;
    int  kind;
    if (inc || dec || load) begin
      check("inc_dec_exclusive", {31'd0, inc & dec}, 32'd0);
      kind = load ? 2 : (inc ? 0 : 1);
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got inc=%0b dec=%0b load=%0b expected none (cycle %0d)",
                 inc, dec, load, cyc);
      end else begin
        e = q.pop_front();
        check("pulse_kind", kind, e.kind);
        check("pulse_cycle", cyc, e.at);
        if (e.kind == 2) check("load_din", {24'd0, din}, {24'd0, e.data});
      end
    end
  end

  initial begin
    logic [1:0] nab;
    logic [1:0] ab_hold;
    int         r;
    int         gap;
    int         glen;
    int         ch;

    // Reset with {a,b}=00 held.
    settle(3);
    check("rst_inc", inc, 1'b0);
    check("rst_dec", dec, 1'b0);
    check("rst_load", load, 1'b0);
    check("rst_din", din, 0);
    check("rst_err", err, 1'b0);
    reset_n = 1'b1;
    settle(20);

    // Four forward steps, ten cycles apart.
    for (int i = 0; i < 4; i++) begin
      drive(nxt[ab_m], 1'b0);
      settle(10);
      check("fwd_err", err, err_m);
    end

    // Three reverse steps.
    for (int i = 0; i < 3; i++) begin
      drive(nxt[nxt[nxt[ab_m]]], 1'b0);
      settle(10);
      check("rev_err", err, err_m);
    end

    // Two-cycle glitch on a_in, then a forward step proves the phase did not move.
    a_in = ~a_in;
    settle(2);
    a_in = ab_m[1];
    settle(10);
    drive(nxt[ab_m], 1'b0);
    settle(10);

    // Double-bit jump sets err; err_clr clears it; err_clr together with a jump leaves it set.
    drive(~ab_m, 1'b0);
    settle(10);
    check("jump_err_set", err, 1'b1);
    clear_err();
    check("err_cleared", err, 1'b0);
    drive(~ab_m, 1'b0);
    settle(LAT - 1);
    err_clr = 1'b1;
    settle(1);
    err_clr = 1'b0;
    settle(5);
    check("set_beats_clear", err, 1'b1);
    clear_err();

    // Index edge coinciding with a forward step: load with preset, no inc.
    preset = 8'hA5;
    drive(nxt[ab_m], 1'b1);
    settle(10);
    drive(ab_m, 1'b0);
    settle(10);

    // Randomized steps, jumps, glitches and index edges.
    for (int it = 0; it < 40; it++) begin
      r   = $urandom_range(0, 9);
      gap = $urandom_range(LAT + 4, LAT + 12);
      if (r <= 3) begin
        drive(nxt[ab_m], idx_m);
      end else if (r <= 6) begin
        drive(nxt[nxt[nxt[ab_m]]], idx_m);
      end else if (r == 7) begin
        drive(~ab_m, idx_m);
      end else if (r == 8) begin
        glen = $urandom_range(1, FILT - 1);
        ch   = $urandom_range(0, 1);
        if (ch == 0) a_in = ~a_in; else b_in = ~b_in;
        settle(glen);
        a_in = ab_m[1];
        b_in = ab_m[0];
      end else begin
        preset = N'($urandom);
        nab = ($urandom_range(0, 1) == 1) ? nxt[ab_m] : ab_m;
        drive(nab, ~idx_m);
      end
      settle(gap);
      check("rand_err", err, err_m);
      if ($urandom_range(0, 3) == 0) clear_err();
    end

    // Reset during an inc pulse, then release with {a,b}=10.
    drive(nxt[ab_m], idx_m);
    settle(LAT);
    check("pulse_before_reset", inc, 1'b1);
    reset_n = 1'b0;
    settle(1);
    check("mid_rst_inc", inc, 1'b0);
    check("mid_rst_dec", dec, 1'b0);
    check("mid_rst_load", load, 1'b0);
    check("mid_rst_din", din, 0);
    check("mid_rst_err", err, 1'b0);
    a_in   = 1'b1;
    b_in   = 1'b0;
    idx_in = 1'b0;
    ab_m   = 2'b10;
    idx_m  = 1'b0;
    err_m  = 1'b0;
    settle(2);
    reset_n = 1'b1;
    settle(30);
    check("init_no_err", err, 1'b0);
    drive(nxt[ab_m], 1'b0);
    settle(10);
    check("after_init_err", err, err_m);

    settle(20);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: got no completion expected finish before 200000 time units");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
